// File: rtl/msu_multi_stream.sv
// msu_multi_stream: round-robin sector reader that feeds NUM_CH MSU stream FIFOs from one HPS sd_* port.
// Rev 1.0
`default_nettype none

module msu_multi_stream #(
  parameter int NUM_CH          = 2,
  parameter int LBA_W           = 32,
  parameter int LEVEL_W         = 16,
  parameter int FIFO_WORDS      = 16128,
  parameter int SECTOR_WORDS    = 256,
  parameter int PREFILL_SECTORS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          seek,
  input  logic [NUM_CH*LBA_W-1:0]    seek_lba,
  input  logic [NUM_CH-1:0]          hps_seek_done,
  input  logic [NUM_CH*LEVEL_W-1:0]  fifo_usedw,
  input  logic                       sd_buff_wr,
  input  logic [NUM_CH-1:0]          sd_ack,
  output logic [NUM_CH-1:0]          sd_rd,
  output logic [LBA_W-1:0]           sd_lba,
  output logic [NUM_CH-1:0]          hps_seek_pulse,
  output logic [NUM_CH-1:0]          fifo_clear,
  output logic [NUM_CH-1:0]          fifo_wr,
  output logic [NUM_CH-1:0]          fifo_busy,
  output logic [NUM_CH-1:0]          seek_finished,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          short_sector
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PF_W = $clog2(PREFILL_SECTORS + 1);
  localparam int WC_W = $clog2(SECTOR_WORDS + 1) + 1;

  localparam logic [LEVEL_W:0] c_SECTOR_LVL = (LEVEL_W+1)'(SECTOR_WORDS);
  localparam logic [LEVEL_W:0] c_FIFO_LVL   = (LEVEL_W+1)'(FIFO_WORDS);
  localparam logic [PF_W-1:0]  c_PREFILL    = PF_W'(PREFILL_SECTORS);
  localparam logic [WC_W-1:0]  c_SECTOR_CNT = WC_W'(SECTOR_WORDS);
  localparam logic [CH_W-1:0]  c_LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]    c_NUM_CH     = (CH_W+1)'(NUM_CH);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_REQ      = 3'd1;
  localparam logic [2:0] c_WAIT_ACK = 3'd2;
  localparam logic [2:0] c_XFER     = 3'd3;
  localparam logic [2:0] c_DONE     = 3'd4;

  logic [NUM_CH-1:0] r_seek_d, r_done_d, r_running;
  logic [NUM_CH-1:0] w_seek_edge, w_done_rise, w_elig, w_cur_oh;
  logic [LBA_W-1:0]  r_next_lba [NUM_CH];
  logic [PF_W-1:0]   r_prefill  [NUM_CH];
  logic [2:0]        r_state;
  logic [CH_W-1:0]   r_cur, r_ptr, w_pick;
  logic [CH_W:0]     w_idx;
  logic              w_found, r_stale;
  logic [WC_W-1:0]   r_words;

  assign w_seek_edge = seek & ~r_seek_d;
  assign w_done_rise = hps_seek_done & ~r_done_d;
  assign w_cur_oh    = NUM_CH'(1) << r_cur;
  assign busy        = fifo_busy | ~seek_finished;

  // Widened by one bit so a near-full level plus one sector cannot wrap.
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_elig
      assign w_elig[c] = r_running[c] &&
        (({1'b0, fifo_usedw[c*LEVEL_W +: LEVEL_W]} + c_SECTOR_LVL) <= c_FIFO_LVL);
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = {1'b0, r_ptr} + (CH_W+1)'(i);
      if (w_idx >= c_NUM_CH) w_idx = w_idx - c_NUM_CH;
      if (!w_found && w_elig[w_idx[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[CH_W-1:0];
      end
    end
  end

  // A seek arriving in the same cycle as a word already suppresses that word.
  always_comb begin
    fifo_wr = '0;
    if (r_state == c_XFER && !r_stale && !w_seek_edge[r_cur] && sd_buff_wr && sd_ack[r_cur])
      fifo_wr = w_cur_oh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seek_d       <= '0;
      r_done_d       <= '0;
      r_running      <= '0;
      hps_seek_pulse <= '0;
      fifo_clear     <= '0;
      fifo_busy      <= '0;
      seek_finished  <= '1;
      short_sector   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_next_lba[c] <= '0;
        r_prefill[c]  <= '0;
      end
      r_state <= c_IDLE;
      r_cur   <= '0;
      r_ptr   <= '0;
      r_stale <= 1'b0;
      r_words <= '0;
      sd_rd   <= '0;
      sd_lba  <= '0;
    end else begin
      r_seek_d       <= seek;
      r_done_d       <= hps_seek_done;
      hps_seek_pulse <= w_seek_edge;
      fifo_clear     <= w_seek_edge;

      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_cur   <= w_pick;
            sd_lba  <= r_next_lba[w_pick];
            r_stale <= w_seek_edge[w_pick];
            r_state <= c_REQ;
          end
        end
        c_REQ: begin
          sd_rd <= w_cur_oh;
          if (w_seek_edge[r_cur]) r_stale <= 1'b1;
          r_state <= c_WAIT_ACK;
        end
        c_WAIT_ACK: begin
          if (w_seek_edge[r_cur]) r_stale <= 1'b1;
          if (sd_ack[r_cur]) begin
            sd_rd   <= '0;
            r_words <= '0;
            r_state <= c_XFER;
          end
        end
        c_XFER: begin
          if (w_seek_edge[r_cur]) r_stale <= 1'b1;
          if (sd_ack[r_cur] && sd_buff_wr && r_words != '1)
            r_words <= r_words + 1'b1;
          if (!sd_ack[r_cur]) r_state <= c_DONE;
        end
        c_DONE: begin
          if (!r_stale) begin
            r_next_lba[r_cur] <= r_next_lba[r_cur] + 1'b1;
            if (r_prefill[r_cur] < c_PREFILL) begin
              r_prefill[r_cur] <= r_prefill[r_cur] + 1'b1;
              if (r_prefill[r_cur] == c_PREFILL - 1'b1) fifo_busy[r_cur] <= 1'b0;
            end
            if (r_words != c_SECTOR_CNT) short_sector[r_cur] <= 1'b1;
          end
          r_ptr   <= (r_cur == c_LAST_CH) ? '0 : r_cur + 1'b1;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase

      // Placed after the arbiter so a seek overrides a same-cycle DONE update.
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_done_rise[c]) seek_finished[c] <= 1'b1;
        if (w_seek_edge[c]) begin
          r_next_lba[c]    <= seek_lba[c*LBA_W +: LBA_W];
          r_prefill[c]     <= '0;
          fifo_busy[c]     <= 1'b1;
          seek_finished[c] <= 1'b0;
          short_sector[c]  <= 1'b0;
          r_running[c]     <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_msu_multi_stream.sv
// tb_msu_multi_stream: directed checks of seek, round-robin streaming, full-FIFO skip, stale drop, wrap and reset.
// Rev 1.0
`default_nettype none

module tb_msu_multi_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  seek = '0;
  logic [1:0]  hps_seek_done = '0;
  logic [1:0]  sd_ack = '0;
  logic        sd_buff_wr = 1'b0;
  logic [31:0] lba0 = '0, lba1 = '0;
  logic [15:0] usedw0 = '0, usedw1 = '0;

  logic [1:0]  sd_rd, hps_seek_pulse, fifo_clear, fifo_wr, fifo_busy, seek_finished, busy, short_sector;
  logic [31:0] sd_lba;

  int total = 0;
  int bad   = 0;

  msu_multi_stream dut (
    .clk            (clk),
    .reset          (reset),
    .seek           (seek),
    .seek_lba       ({lba1, lba0}),
    .hps_seek_done  (hps_seek_done),
    .fifo_usedw     ({usedw1, usedw0}),
    .sd_buff_wr     (sd_buff_wr),
    .sd_ack         (sd_ack),
    .sd_rd          (sd_rd),
    .sd_lba         (sd_lba),
    .hps_seek_pulse (hps_seek_pulse),
    .fifo_clear     (fifo_clear),
    .fifo_wr        (fifo_wr),
    .fifo_busy      (fifo_busy),
    .seek_finished  (seek_finished),
    .busy           (busy),
    .short_sector   (short_sector)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output int ch, output logic [31:0] lba);
    int n;
    n   = 0;
    ch  = -1;
    lba = '0;
    while (sd_rd == 2'b00 && n < 100) begin
      tick();
      n++;
    end
    if (sd_rd == 2'b00) begin
      check("req_timeout", 64'd0, 64'd1);
    end else begin
      ch  = sd_rd[1] ? 1 : 0;
      lba = sd_lba;
      check("rd_onehot", 64'(sd_rd == 2'b01 || sd_rd == 2'b10), 64'd1);
    end
  endtask

  task automatic expect_req(input string tag, input int exp_ch, input logic [31:0] exp_lba);
    int          ch;
    logic [31:0] lba;
    wait_req(ch, lba);
    check({tag, "_ch"}, 64'(ch), 64'(exp_ch));
    check({tag, "_lba"}, 64'(lba), 64'(exp_lba));
  endtask

  // Plays the HPS side of one sector; words from index seek_at onward are counted separately.
  task automatic xfer(input int ch, input int n, input int seek_at, output int pre, output int post);
    pre  = 0;
    post = 0;
    sd_ack[ch] = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == seek_at) seek[ch] = 1'b1;
      sd_buff_wr = 1'b1;
      #1;
      if (fifo_wr[ch]) begin
        if (seek_at >= 0 && i >= seek_at) post++;
        else pre++;
      end
      @(posedge clk);
      #1;
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 2'b00;
    seek[ch]   = 1'b0;
    tick();
  endtask

  initial begin
    int          pre, post, wrs;
    logic [31:0] e;

    repeat (3) tick();
    check("rst_sd_rd", 64'(sd_rd), 64'd0);
    check("rst_sd_lba", 64'(sd_lba), 64'd0);
    check("rst_seek_fin", 64'(seek_finished), 64'd3);
    check("rst_fifo_busy", 64'(fifo_busy), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_short", 64'(short_sector), 64'd0);
    check("rst_pulse", 64'(hps_seek_pulse), 64'd0);
    check("rst_clear", 64'(fifo_clear), 64'd0);
    reset = 1'b0;
    tick();

    // Single channel prefill from LBA 100.
    lba0    = 32'd100;
    seek[0] = 1'b1;
    tick();
    check("seek0_pulse", 64'(hps_seek_pulse), 64'd1);
    check("seek0_clear", 64'(fifo_clear), 64'd1);
    check("seek0_fbusy", 64'(fifo_busy), 64'd1);
    check("seek0_fin", 64'(seek_finished), 64'd2);
    check("seek0_busy", 64'(busy), 64'd1);
    seek[0] = 1'b0;
    tick();
    check("seek0_pulse_end", 64'(hps_seek_pulse), 64'd0);
    check("seek0_clear_end", 64'(fifo_clear), 64'd0);

    wrs = 0;
    for (int k = 0; k < 32; k++) begin
      expect_req("pf", 0, 32'd100 + 32'(k));
      check("pf_fbusy", 64'(fifo_busy[0]), 64'd1);
      xfer(0, 256, -1, pre, post);
      wrs += pre;
    end
    check("pf_words", 64'(wrs), 64'd8192);
    expect_req("pf_next", 0, 32'd132);
    check("pf_fbusy_done", 64'(fifo_busy[0]), 64'd0);
    check("pf_busy_noseekdone", 64'(busy[0]), 64'd1);
    usedw0 = 16'd16128;
    xfer(0, 256, -1, pre, post);
    hps_seek_done[0] = 1'b1;
    tick();
    tick();
    check("seekdone0_fin", 64'(seek_finished[0]), 64'd1);
    check("seekdone0_busy", 64'(busy[0]), 64'd0);

    // Both channels; pointer sits at ch1 after the last ch0 sector.
    lba0 = 32'd10;
    lba1 = 32'd500;
    seek = 2'b11;
    tick();
    check("seek2_pulse", 64'(hps_seek_pulse), 64'd3);
    seek   = 2'b00;
    usedw0 = 16'd0;
    expect_req("rr0", 1, 32'd500);
    xfer(1, 256, -1, pre, post);
    expect_req("rr1", 0, 32'd10);
    xfer(0, 256, -1, pre, post);
    expect_req("rr2", 1, 32'd501);
    xfer(1, 256, -1, pre, post);
    expect_req("rr3", 0, 32'd11);
    xfer(0, 256, -1, pre, post);

    // ch0 one word short of a sector of space is skipped.
    expect_req("full0", 1, 32'd502);
    usedw0 = 16'd15873;
    xfer(1, 256, -1, pre, post);
    expect_req("full1", 1, 32'd503);
    xfer(1, 256, -1, pre, post);
    expect_req("full2", 1, 32'd504);
    usedw0 = 16'd15872;
    xfer(1, 256, -1, pre, post);

    // Seek on the active channel mid-sector.
    expect_req("stale_req", 0, 32'd12);
    lba0 = 32'd7;
    xfer(0, 256, 100, pre, post);
    check("stale_pre", 64'(pre), 64'd100);
    check("stale_post", 64'(post), 64'd0);
    check("stale_fbusy", 64'(fifo_busy[0]), 64'd1);
    expect_req("stale_other", 1, 32'd505);
    xfer(1, 256, -1, pre, post);
    expect_req("stale_restart", 0, 32'd7);
    check("stale_restart_fbusy", 64'(fifo_busy[0]), 64'd1);
    usedw0 = 16'd16128;
    usedw1 = 16'd16128;
    xfer(0, 256, -1, pre, post);
    repeat (5) tick();
    check("all_full_idle", 64'(sd_rd), 64'd0);

    // ch1: seek to the last LBA, late seek-done, one short sector, full prefill.
    lba1    = 32'hFFFF_FFFF;
    seek[1] = 1'b1;
    tick();
    check("seek1_pulse", 64'(hps_seek_pulse), 64'd2);
    seek[1] = 1'b0;
    repeat (39) tick();
    check("seek1_fin_wait", 64'(seek_finished[1]), 64'd0);
    hps_seek_done[1] = 1'b1;
    tick();
    check("seek1_fin", 64'(seek_finished[1]), 64'd1);
    check("seek1_busy", 64'(busy[1]), 64'd1);
    check("seek1_short", 64'(short_sector[1]), 64'd0);
    usedw1 = 16'd0;
    for (int k = 0; k < 32; k++) begin
      e = 32'hFFFF_FFFF + 32'(k);
      expect_req("wrap", 1, e);
      check("wrap_busy", 64'(busy[1]), 64'd1);
      if (k == 1) check("short_set", 64'(short_sector[1]), 64'd1);
      xfer(1, (k == 0) ? 200 : 256, -1, pre, post);
    end
    expect_req("wrap_next", 1, 32'd31);
    check("wrap_fbusy_done", 64'(fifo_busy[1]), 64'd0);
    check("wrap_busy_done", 64'(busy[1]), 64'd0);
    check("short_sticky", 64'(short_sector[1]), 64'd1);

    // Asynchronous reset in the middle of a sector.
    sd_ack[1] = 1'b1;
    tick();
    sd_buff_wr = 1'b1;
    repeat (50) tick();
    check("pre_rst_wr", 64'(fifo_wr), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_sd_rd", 64'(sd_rd), 64'd0);
    check("arst_sd_lba", 64'(sd_lba), 64'd0);
    check("arst_wr", 64'(fifo_wr), 64'd0);
    check("arst_fin", 64'(seek_finished), 64'd3);
    check("arst_fbusy", 64'(fifo_busy), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_short", 64'(short_sector), 64'd0);
    tick();
    reset = 1'b0;
    wrs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fifo_wr != 2'b00) wrs++;
    end
    check("late_words", 64'(wrs), 64'd0);
    check("post_rst_rd", 64'(sd_rd), 64'd0);
    sd_buff_wr = 1'b0;
    sd_ack     = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
